// File: rtl/mdc_stream_pkg.sv
// Shared definitions for the coprocessor stream input stage:
// job FSM state type and default sizing constants.
package mdc_stream_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_DEPTH      = 4;
    localparam int DEF_CNT_WIDTH  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/stream_fifo_core.sv
// Pointer/level FIFO used as the elastic buffer of the stream input stage.
// Full and empty are derived from the occupancy counter, so the pointers
// can wrap freely modulo DEPTH without needing an extra wrap bit.
module stream_fifo_core
    import mdc_stream_pkg::*;
#(
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int DEPTH      = DEF_DEPTH,
    localparam int PTR_W      = $clog2(DEPTH),
    localparam int LVL_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [LVL_W-1:0]      level_o
);

    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wrPtr;
    logic [PTR_W-1:0]      r_rdPtr;
    logic [LVL_W-1:0]      r_level;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;

    assign w_full  = (r_level == FULL_LVL);
    assign w_empty = (r_level == '0);

    // A push into a full buffer or a pop from an empty one is dropped;
    // a soft clear suppresses both so the flush wins over traffic.
    assign w_push = push_i && !w_full  && !clear_i;
    assign w_pop  = pop_i  && !w_empty && !clear_i;

    // Storage array; reset to zero so the output word is defined after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wrPtr] <= data_i;
        end
    end

    // Write and read pointers advance independently and wrap modulo DEPTH.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else if (clear_i) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
        end
    end

    // Occupancy counter; a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_level <= '0;
        end else if (clear_i) begin
            r_level <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign data_o  = r_mem[r_rdPtr];
    assign full_o  = w_full;
    assign empty_o = w_empty;
    assign level_o = r_level;

endmodule

// File: rtl/stream_fifo_counter.sv
// Elastic input stage between the stream-to-flat adapter and the datapath.
// Buffers up to DEPTH words, admits exactly the programmed job length and
// pulses done once the last word has been taken by the datapath. The
// upstream ready depends only on registered state, which breaks the
// combinational ready path from the datapath back to the streamer.
module stream_fifo_counter
    import mdc_stream_pkg::*;
#(
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int DEPTH      = DEF_DEPTH,
    parameter  int CNT_WIDTH  = DEF_CNT_WIDTH,
    localparam int LVL_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [CNT_WIDTH-1:0]  len_i,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [LVL_W-1:0]      level_o
);

    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_len;
    logic [CNT_WIDTH-1:0] r_inCnt;
    logic [CNT_WIDTH-1:0] r_outCnt;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_lastPop;
    logic [CNT_WIDTH-1:0] w_outCntNext;

    // Ready is built from registered state only: FSM state, buffer level
    // and the admitted-word count, never from out_ready.
    assign in_ready     = (r_state == RUN) && !w_full && (r_inCnt < r_len);
    assign out_valid    = !w_empty;
    assign w_push       = in_valid && in_ready;
    assign w_pop        = out_valid && out_ready;
    assign w_outCntNext = r_outCnt + CNT_WIDTH'(1);
    assign w_lastPop    = (r_state == RUN) && w_pop && (w_outCntNext == r_len);

    stream_fifo_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (w_push),
        .data_i  (in_data),
        .pop_i   (w_pop),
        .data_o  (out_data),
        .full_o  (w_full),
        .empty_o (w_empty),
        .level_o (level_o)
    );

    // Job FSM with registered busy/done; clear returns to IDLE without a done pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_len   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (clear_i) begin
            r_state <= IDLE;
            r_len   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start_i) begin
                        if (len_i == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            r_len   <= len_i;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (w_lastPop) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Admitted and delivered word counters, restarted whenever a job is accepted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_inCnt  <= '0;
            r_outCnt <= '0;
        end else if (clear_i) begin
            r_inCnt  <= '0;
            r_outCnt <= '0;
        end else if ((r_state == IDLE) && start_i) begin
            r_inCnt  <= '0;
            r_outCnt <= '0;
        end else if (r_state == RUN) begin
            if (w_push) begin
                r_inCnt <= r_inCnt + CNT_WIDTH'(1);
            end
            if (w_pop) begin
                r_outCnt <= w_outCntNext;
            end
        end
    end

    assign busy_o = r_busy;
    assign done_o = r_done;

endmodule

// File: tb/tb_stream_fifo_counter.sv
// Randomized self-checking bench for stream_fifo_counter. A queue-based
// job model predicts every output each cycle.
module tb_stream_fifo_counter;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = 16;
    localparam int LW    = 3;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          clear_i = 1'b0;
    logic          start_i = 1'b0;
    logic [CW-1:0] len_i = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          busy_o;
    logic          done_o;
    logic [LW-1:0] level_o;

    int totalChecks = 0;
    int badChecks   = 0;

    // Job model: words in flight, phase (0 idle, 1 running, 2 finishing),
    // programmed length and words admitted / delivered so far.
    logic [DW-1:0] mFifo[$];
    int            mPhase = 0;
    int unsigned   mLen = 0;
    int unsigned   mIn = 0;
    int unsigned   mOut = 0;
    logic [DW-1:0] nextWord = '0;
    bit            seqData = 1'b1;

    stream_fifo_counter #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (clear_i),
        .start_i   (start_i),
        .len_i     (len_i),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .level_o   (level_o)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelClear();
        mFifo.delete();
        mPhase = 0;
        mLen   = 0;
        mIn    = 0;
        mOut   = 0;
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, then
    // advance the model by what the coming rising edge will do.
    task automatic applyStimulus(input bit st, input int unsigned ln, input bit clr, input bit vld, input bit rdy);
        bit eReady;
        bit eValid;
        bit push;
        bit pop;
        @(negedge clk_i);
        start_i   = st;
        len_i     = CW'(ln);
        clear_i   = clr;
        in_valid  = vld;
        in_data   = nextWord;
        out_ready = rdy;
        #1;
        eReady = (mPhase == 1) && (mFifo.size() < DEPTH) && (mIn < mLen);
        eValid = (mFifo.size() != 0);
        checkOutput("in_ready",  32'(in_ready),  32'(eReady));
        checkOutput("out_valid", 32'(out_valid), 32'(eValid));
        checkOutput("busy",      32'(busy_o),    32'(mPhase == 1));
        checkOutput("done",      32'(done_o),    32'(mPhase == 2));
        checkOutput("level",     32'(level_o),   32'(mFifo.size()));
        if (eValid) begin
            checkOutput("out_data", out_data, mFifo[0]);
        end
        push = vld && eReady;
        pop  = eValid && rdy;
        if (clr) begin
            modelClear();
        end else begin
            case (mPhase)
                0: begin
                    if (st) begin
                        if (ln == 0) begin
                            mPhase = 2;
                        end else begin
                            mLen   = ln;
                            mIn    = 0;
                            mOut   = 0;
                            mPhase = 1;
                        end
                    end
                end
                1: begin
                    if (pop) begin
                        void'(mFifo.pop_front());
                        mOut++;
                    end
                    if (push) begin
                        mFifo.push_back(nextWord);
                        mIn++;
                    end
                    if (pop && (mOut == mLen)) begin
                        mPhase = 2;
                    end
                end
                default: mPhase = 0;
            endcase
            if (push) begin
                nextWord = seqData ? nextWord + 32'd1 : $urandom();
            end
        end
    endtask

    // Keep the job running with random traffic until the model is idle again.
    task automatic runUntilIdle(input int vPct, input int rPct, input bit rndStart, input int maxCycles);
        int n = 0;
        while (mPhase != 0 && n < maxCycles) begin
            applyStimulus(rndStart && ($urandom_range(0, 3) == 0),
                          $urandom_range(0, 9), 1'b0,
                          int'($urandom_range(0, 99)) < vPct,
                          int'($urandom_range(0, 99)) < rPct);
            n++;
        end
        if (mPhase != 0) begin
            checkOutput("jobTimeout", 32'd1, 32'd0);
        end
    endtask

    // Start a job with the output stalled and feed until three words sit in the buffer.
    task automatic fillToThree(input int unsigned ln);
        int n = 0;
        applyStimulus(1'b1, ln, 1'b0, 1'b0, 1'b0);
        while (mFifo.size() < 3 && n < 20) begin
            applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
            n++;
        end
        if (mFifo.size() != 3) begin
            checkOutput("fillTimeout", 32'd1, 32'd0);
        end
    endtask

    // Asynchronous reset in the middle of a cycle, checked before the next edge.
    task automatic doReset();
        @(negedge clk_i);
        start_i   = 1'b0;
        clear_i   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_ni    = 1'b0;
        #1;
        checkOutput("rstLevel", 32'(level_o),   32'd0);
        checkOutput("rstValid", 32'(out_valid), 32'd0);
        checkOutput("rstBusy",  32'(busy_o),    32'd0);
        checkOutput("rstDone",  32'(done_o),    32'd0);
        checkOutput("rstReady", 32'(in_ready),  32'd0);
        checkOutput("rstData",  out_data,       32'd0);
        modelClear();
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        #1;
        checkOutput("resetReady", 32'(in_ready),  32'd0);
        checkOutput("resetValid", 32'(out_valid), 32'd0);
        checkOutput("resetData",  out_data,       32'd0);
        checkOutput("resetBusy",  32'(busy_o),    32'd0);
        checkOutput("resetDone",  32'(done_o),    32'd0);
        checkOutput("resetLevel", 32'(level_o),   32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Basic job of five sequential words.
        seqData  = 1'b1;
        nextWord = 32'h10;
        applyStimulus(1'b1, 5, 1'b0, 1'b0, 1'b1);
        runUntilIdle(100, 100, 1'b0, 50);
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);

        // Backpressure: output stalled for ten cycles.
        nextWord = 32'h100;
        applyStimulus(1'b1, 8, 1'b0, 1'b0, 1'b0);
        repeat (10) applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
        checkOutput("bpLevel", 32'(level_o),  32'd4);
        checkOutput("bpReady", 32'(in_ready), 32'd0);
        runUntilIdle(100, 100, 1'b0, 60);

        // Overrun guard: upstream keeps offering words past the job length.
        nextWord = 32'h300;
        applyStimulus(1'b1, 3, 1'b0, 1'b1, 1'b1);
        runUntilIdle(100, 100, 1'b0, 40);
        repeat (3) applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b1);

        // Zero-length job.
        applyStimulus(1'b1, 0, 1'b0, 1'b1, 1'b1);
        repeat (3) applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b1);

        // Random traffic with wrapping pointers and ignored start pulses.
        seqData  = 1'b0;
        nextWord = $urandom();
        applyStimulus(1'b1, 20, 1'b0, 1'b0, 1'b0);
        runUntilIdle(50, 50, 1'b1, 400);
        for (int j = 0; j < 8; j++) begin
            applyStimulus(1'b1, $urandom_range(1, 30), 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            runUntilIdle(int'($urandom_range(30, 90)), int'($urandom_range(30, 90)), 1'b1, 2000);
            applyStimulus(1'b0, 0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Soft clear with three words buffered, then a short job.
        seqData  = 1'b1;
        nextWord = 32'h200;
        fillToThree(8);
        applyStimulus(1'b0, 0, 1'b1, 1'b1, 1'b1);
        repeat (2) applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2, 1'b0, 1'b1, 1'b1);
        runUntilIdle(100, 100, 1'b0, 30);

        // Asynchronous reset with three words buffered, then a short job.
        nextWord = 32'h400;
        fillToThree(8);
        doReset();
        repeat (2) applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2, 1'b0, 1'b1, 1'b1);
        runUntilIdle(100, 100, 1'b0, 30);
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
